// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the byte-wide RAM and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [1:0]        grant;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, grant, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, grant, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between IF fetches and MEM accesses, sequencing bytes little-endian.
// Define MEM_PREEMPT_EN to let a MEM request abandon an in-flight IF fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_t;

  state_t            r_state,     w_state;
  logic [1:0]        r_grant,     w_grant;
  logic [ADDR_W-1:0] r_ram_a,     w_ram_a;
  logic [7:0]        r_ram_dout,  w_ram_dout;
  logic              r_ram_wr,    w_ram_wr;
  logic              r_if_done,   w_if_done;
  logic              r_mem_done,  w_mem_done;
  logic [31:0]       r_if_data,   w_if_data;
  logic [31:0]       r_mem_rdata, w_mem_rdata;
  logic [31:0]       r_buf,       w_buf;
  logic [CNT_W-1:0]  r_cnt,       w_cnt;
  logic [CNT_W-1:0]  r_len,       w_len;

  logic [CNT_W-1:0]  w_step;
  logic [1:0]        w_byte_idx;
  logic [1:0]        w_wr_sel;
  logic [7:0]        w_wr_byte;
  logic [31:0]       w_rd_word;
  logic [CNT_W-1:0]  w_mem_n;
  logic              w_mem_elig;
  logic              w_if_elig;
  logic              w_take_mem;

  // r_cnt counts edges since the grant edge minus one; w_step is the edge index being taken now
  assign w_step     = r_cnt + CNT_W'(1);
  assign w_byte_idx = 2'(r_cnt - CNT_W'(1));
  assign w_wr_sel   = w_step[1:0];
  assign w_wr_byte  = 8'(bus.mem_wdata >> {w_wr_sel, 3'b000});
  assign w_mem_n    = (bus.mem_len == 2'b00) ? CNT_W'(1) :
                      (bus.mem_len == 2'b01) ? CNT_W'(2) : CNT_W'(4);
  assign w_mem_elig = bus.mem_req && !r_mem_done;
  assign w_if_elig  = bus.if_req && !r_if_done;

  // Assembly buffer with the byte arriving on ram_din this edge merged in
  always_comb begin
    w_rd_word = r_buf;
    case (w_byte_idx)
      2'd0:    w_rd_word[7:0]   = bus.ram_din;
      2'd1:    w_rd_word[15:8]  = bus.ram_din;
      2'd2:    w_rd_word[23:16] = bus.ram_din;
      default: w_rd_word[31:24] = bus.ram_din;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_grant     = r_grant;
    w_ram_a     = r_ram_a;
    w_ram_dout  = r_ram_dout;
    w_ram_wr    = r_ram_wr;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    w_if_data   = r_if_data;
    w_mem_rdata = r_mem_rdata;
    w_buf       = r_buf;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_take_mem  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_mem_elig) begin
          w_take_mem = 1'b1;
        end else if (w_if_elig) begin
          w_state = S_IF_RD;
          w_grant = 2'b01;
          w_ram_a = ADDR_W'(bus.if_addr);
          w_buf   = '0;
          w_cnt   = '0;
          w_len   = CNT_W'(4);
        end
      end

      S_IF_RD: begin
        if (bus.if_flush) begin
          w_state = S_IDLE;
          w_grant = 2'b00;
          w_cnt   = '0;
`ifdef MEM_PREEMPT_EN
        end else if (w_mem_elig && (r_cnt != r_len)) begin
          w_take_mem = 1'b1;
`endif
        end else begin
          if (r_cnt != '0) w_buf = w_rd_word;
          if (r_cnt == r_len) begin
            w_state   = S_IDLE;
            w_grant   = 2'b00;
            w_if_data = w_rd_word;
            w_if_done = 1'b1;
            w_cnt     = '0;
          end else begin
            w_cnt = w_step;
            if (w_step < r_len) w_ram_a = r_ram_a + ADDR_W'(1);
          end
        end
      end

      S_MEM_RD: begin
        if (r_cnt != '0) w_buf = w_rd_word;
        if (r_cnt == r_len) begin
          w_state     = S_IDLE;
          w_grant     = 2'b00;
          w_mem_rdata = w_rd_word;
          w_mem_done  = 1'b1;
          w_cnt       = '0;
        end else begin
          w_cnt = w_step;
          if (w_step < r_len) w_ram_a = r_ram_a + ADDR_W'(1);
        end
      end

      S_MEM_WR: begin
        if (w_step == r_len) begin
          w_state    = S_IDLE;
          w_grant    = 2'b00;
          w_ram_wr   = 1'b0;
          w_mem_done = 1'b1;
          w_cnt      = '0;
        end else begin
          w_cnt      = w_step;
          w_ram_a    = r_ram_a + ADDR_W'(1);
          w_ram_dout = w_wr_byte;
          w_ram_wr   = 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_grant = 2'b00;
      end
    endcase

    // MEM grant edge, reached from IDLE or by pre-empting an IF fetch
    if (w_take_mem) begin
      w_grant = 2'b10;
      w_ram_a = ADDR_W'(bus.mem_addr);
      w_cnt   = '0;
      w_len   = w_mem_n;
      w_buf   = '0;
      if (bus.mem_we) begin
        w_state    = S_MEM_WR;
        w_ram_wr   = 1'b1;
        w_ram_dout = bus.mem_wdata[7:0];
      end else begin
        w_state = S_MEM_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'b00;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
    end else if (rdy) begin
      r_state     <= w_state;
      r_grant     <= w_grant;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
      r_if_done   <= w_if_done;
      r_mem_done  <= w_mem_done;
      r_if_data   <= w_if_data;
      r_mem_rdata <= w_mem_rdata;
      r_buf       <= w_buf;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
    end
  end

  // A frozen write must not strobe the RAM; the pending byte is written on resume
  assign bus.ram_wr    = r_ram_wr & rdy;
  assign bus.ram_a     = r_ram_a;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.grant     = r_grant;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a byte-array reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: one-cycle registered read, frozen with the global enable
  logic [7:0]  ram_mem [0:65535];
  logic [7:0]  ram_q = 8'h00;
  logic        pl_clr = 1'b0;
  logic        pl_en = 1'b0;
  logic [31:0] pl_a = '0;
  logic [7:0]  pl_d = '0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (rdy) ram_q <= ram_mem[bus.ram_a[15:0]];
    if (pl_clr) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= 8'h00;
    end else if (pl_en) begin
      ram_mem[pl_a[15:0]] <= pl_d;
    end else if (bus.ram_wr) begin
      ram_mem[bus.ram_a[15:0]] <= bus.ram_dout;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign bus.ram_din = ram_q;

  // Reference model: flat byte memory over the full 32-bit address space
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
    return w;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
  endfunction

  function automatic int len_n(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic wait_grant(input logic [1:0] g, output int e0);
    e0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.grant == g) begin e0 = cyc; break; end
    end
  endtask

  task automatic run_if(input logic [31:0] a, output int lat, output logic [31:0] d);
    int e0;
    e0 = -1; lat = -1; d = '0;
    bus.if_addr = a; bus.if_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (e0 < 0 && bus.grant == 2'b01) e0 = cyc;
      if (bus.if_done) begin
        if (e0 >= 0) lat = cyc - e0;
        d = bus.if_data;
        break;
      end
    end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_mem(input logic we, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] d);
    int e0;
    e0 = -1; lat = -1; d = '0;
    bus.mem_we = we; bus.mem_len = len; bus.mem_addr = a; bus.mem_wdata = wd;
    bus.mem_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (e0 < 0 && bus.grant == 2'b10) e0 = cyc;
      if (bus.mem_done) begin
        if (e0 >= 0) lat = cyc - e0;
        d = bus.mem_rdata;
        break;
      end
    end
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    preload(32'h0030, 8'h80);
    for (int k = 0; k < 36; k++) preload(32'h3000 + 32'(k), 8'($urandom));
    @(posedge clk); #1;
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", bus.grant); end
    checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr got %b exp 0", bus.ram_wr); end
    checks++; if (bus.ram_a !== '0) begin errors++; $display("FAIL rst_ram_a got %h exp 0", bus.ram_a); end
    checks++; if (bus.ram_dout !== 8'h00) begin errors++; $display("FAIL rst_ram_dout got %h exp 0", bus.ram_dout); end
    checks++; if ({bus.if_done, bus.mem_done} !== 2'b00) begin errors++; $display("FAIL rst_done got %b exp 00", {bus.if_done, bus.mem_done}); end
    checks++; if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {bus.if_data, bus.mem_rdata}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_if_fetch();
    logic [31:0] exp_d, got;
    logic [31:0] a_seen [4];
    int e0, lat;
    for (int k = 0; k < 4; k++) a_seen[k] = '0;
    exp_d = ref_word(32'h1000, 4);
    e0 = -1; lat = -1; got = '0;
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (e0 < 0 && bus.grant == 2'b01) e0 = cyc;
      if (e0 >= 0 && cyc - e0 < 4) a_seen[cyc - e0] = bus.ram_a;
      if (bus.if_done) begin
        if (e0 >= 0) lat = cyc - e0;
        got = bus.if_data;
        break;
      end
    end
    bus.if_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_seen[k] !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL if_ram_a%0d got %h exp %h", k, a_seen[k], 32'h1000 + 32'(k)); end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL if_latency got %0d exp 5", lat); end
    checks++; if (got !== exp_d) begin errors++; $display("FAIL if_data got %h exp %h", got, exp_d); end
    @(posedge clk); #1;
    checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL if_done_pulse got %b exp 0", bus.if_done); end
  endtask

  task automatic test_mem_write();
    int lat, w0;
    logic [31:0] d;
    w0 = wr_cnt;
    run_mem(1'b1, 2'b10, 32'h2000, 32'hDEADBEEF, lat, d);
    ref_write(32'h2000, 32'hDEADBEEF, 4);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency got %0d exp 4", lat); end
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL wr_strobes got %0d exp 4", wr_cnt - w0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram_mem[16'h2000 + 16'(k)] !== ref_rd(32'h2000 + 32'(k))) begin
        errors++; $display("FAIL wr_byte%0d got %h exp %h", k, ram_mem[16'h2000 + 16'(k)], ref_rd(32'h2000 + 32'(k)));
      end
    end
    run_mem(1'b0, 2'b11, 32'h2000, 32'h0, lat, d);
    checks++; if (d !== ref_word(32'h2000, 4)) begin errors++; $display("FAIL rd4 got %h exp %h", d, ref_word(32'h2000, 4)); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd4_latency got %0d exp 5", lat); end
    run_mem(1'b0, 2'b01, 32'h2001, 32'h0, lat, d);
    checks++; if (d !== ref_word(32'h2001, 2)) begin errors++; $display("FAIL rd2 got %h exp %h", d, ref_word(32'h2001, 2)); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd2_latency got %0d exp 3", lat); end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  first_g;
    logic [31:0] mrd, ifd;
    int md_e, ig_e, nmd, nid;
    first_g = 2'b00; md_e = -1; ig_e = -1; nmd = 0; nid = 0; mrd = '0; ifd = '0;
    bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h30; bus.if_addr = 32'h1000;
    bus.mem_req = 1'b1; bus.if_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (first_g == 2'b00 && bus.grant != 2'b00) first_g = bus.grant;
      if (ig_e < 0 && bus.grant == 2'b01) ig_e = cyc;
      if (bus.mem_done) begin nmd++; md_e = cyc; mrd = bus.mem_rdata; bus.mem_req = 1'b0; end
      if (bus.if_done) begin nid++; ifd = bus.if_data; bus.if_req = 1'b0; end
    end
    checks++; if (first_g !== 2'b10) begin errors++; $display("FAIL sim_first_grant got %b exp 10", first_g); end
    checks++; if (mrd !== ref_word(32'h30, 1)) begin errors++; $display("FAIL sim_mem_rdata got %h exp %h", mrd, ref_word(32'h30, 1)); end
    checks++; if ((md_e >= 0 && ig_e > md_e) !== 1'b1) begin errors++; $display("FAIL sim_idle_gap got if_grant %0d mem_done %0d exp later", ig_e, md_e); end
    checks++; if (nmd !== 1 || nid !== 1) begin errors++; $display("FAIL sim_done_count got mem %0d if %0d exp 1 1", nmd, nid); end
    checks++; if (ifd !== ref_word(32'h1000, 4)) begin errors++; $display("FAIL sim_if_data got %h exp %h", ifd, ref_word(32'h1000, 4)); end
  endtask

  task automatic test_flush();
    logic [31:0] prev, d;
    logic [1:0]  g;
    int e0, nd, w0, lat;
    prev = bus.if_data; w0 = wr_cnt; nd = 0;
    bus.if_addr = 32'h1000; bus.if_req = 1'b1;
    wait_grant(2'b01, e0);
    @(posedge clk); #1;
    bus.if_flush = 1'b1;
    @(posedge clk); #1;
    g = bus.grant;
    if (bus.if_done) nd++;
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.if_done) nd++;
    end
    checks++; if (g !== 2'b00) begin errors++; $display("FAIL flush_grant got %b exp 00", g); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL flush_done got %0d exp 0", nd); end
    checks++; if (bus.if_data !== prev) begin errors++; $display("FAIL flush_if_data got %h exp %h", bus.if_data, prev); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL flush_ram_wr got %0d exp 0", wr_cnt - w0); end
    run_if(32'h2000, lat, d);
    checks++; if (d !== ref_word(32'h2000, 4)) begin errors++; $display("FAIL flush_refetch got %h exp %h", d, ref_word(32'h2000, 4)); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL flush_refetch_lat got %0d exp 5", lat); end
  endtask

  task automatic test_reset_mid_write();
    int e0, lat;
    logic [31:0] d;
    bus.mem_we = 1'b1; bus.mem_len = 2'b10; bus.mem_addr = 32'h2000; bus.mem_wdata = 32'h11223344;
    bus.mem_req = 1'b1;
    wait_grant(2'b10, e0);
    rst = 1'b1; bus.mem_req = 1'b0;
    @(posedge clk); #1;
    // Byte 0 was already strobed at the edge that applied reset
    ref_mem[32'h2000] = 8'h44;
    checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rstw_ram_wr got %b exp 0", bus.ram_wr); end
    checks++; if ({bus.grant, bus.ram_a, bus.ram_dout} !== 42'h0) begin errors++; $display("FAIL rstw_port got %h exp 0", {bus.grant, bus.ram_a, bus.ram_dout}); end
    checks++; if ({bus.if_done, bus.mem_done, bus.if_data, bus.mem_rdata} !== 66'h0) begin errors++; $display("FAIL rstw_outputs got %h exp 0", {bus.if_done, bus.mem_done, bus.if_data, bus.mem_rdata}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ram_mem[16'h2002] !== ref_rd(32'h2002)) begin errors++; $display("FAIL rstw_byte2 got %h exp %h", ram_mem[16'h2002], ref_rd(32'h2002)); end
    run_mem(1'b0, 2'b10, 32'h2000, 32'h0, lat, d);
    checks++; if (d !== ref_word(32'h2000, 4)) begin errors++; $display("FAIL rstw_readback got %h exp %h", d, ref_word(32'h2000, 4)); end
  endtask

  task automatic test_rdy_stall();
    int e0, lat, nd, w0;
    logic [31:0] d;
    nd = 0; lat = -1; d = '0;
    bus.if_addr = 32'h3004; bus.if_req = 1'b1;
    wait_grant(2'b01, e0);
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (bus.if_done) nd++; end
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.if_done) begin lat = cyc - e0; d = bus.if_data; break; end
    end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (lat !== 8 || nd !== 0) begin errors++; $display("FAIL stall_rd_latency got %0d early %0d exp 8 0", lat, nd); end
    checks++; if (d !== ref_word(32'h3004, 4)) begin errors++; $display("FAIL stall_rd_data got %h exp %h", d, ref_word(32'h3004, 4)); end
    // Write frozen for two cycles right after the grant
    w0 = wr_cnt; lat = -1;
    bus.mem_we = 1'b1; bus.mem_len = 2'b11; bus.mem_addr = 32'h3010; bus.mem_wdata = 32'hCAFEF00D;
    bus.mem_req = 1'b1;
    wait_grant(2'b10, e0);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
    rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.mem_done) begin lat = cyc - e0; break; end
    end
    bus.mem_req = 1'b0;
    ref_write(32'h3010, 32'hCAFEF00D, 4);
    @(posedge clk); #1;
    checks++; if (lat !== 6 || wr_cnt - w0 !== 4) begin errors++; $display("FAIL stall_wr got lat %0d strobes %0d exp 6 4", lat, wr_cnt - w0); end
    run_mem(1'b0, 2'b10, 32'h3010, 32'h0, lat, d);
    checks++; if (d !== ref_word(32'h3010, 4)) begin errors++; $display("FAIL stall_wr_readback got %h exp %h", d, ref_word(32'h3010, 4)); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] d, wd;
    wd = $urandom;
    run_mem(1'b1, 2'b10, 32'hFFFF_FFFE, wd, lat, d);
    ref_write(32'hFFFF_FFFE, wd, 4);
    run_mem(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, lat, d);
    checks++; if (d !== ref_word(32'hFFFF_FFFE, 4)) begin errors++; $display("FAIL wrap_mem got %h exp %h", d, ref_word(32'hFFFF_FFFE, 4)); end
    run_if(32'hFFFF_FFFF, lat, d);
    checks++; if (d !== ref_word(32'hFFFF_FFFF, 4)) begin errors++; $display("FAIL wrap_if got %h exp %h", d, ref_word(32'hFFFF_FFFF, 4)); end
  endtask

  task automatic test_preempt();
    int e0, mg_e, md_e, id_e, nmd, nid;
    logic [31:0] mrd, ifd;
    mg_e = -1; md_e = -1; id_e = -1; nmd = 0; nid = 0; mrd = '0; ifd = '0;
    bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = 32'h30;
    bus.if_addr = 32'h3008; bus.if_req = 1'b1;
    wait_grant(2'b01, e0);
    @(posedge clk); #1;
    bus.mem_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mg_e < 0 && bus.grant == 2'b10) mg_e = cyc;
      if (bus.mem_done) begin nmd++; md_e = cyc; mrd = bus.mem_rdata; bus.mem_req = 1'b0; end
      if (bus.if_done) begin nid++; id_e = cyc; ifd = bus.if_data; bus.if_req = 1'b0; end
    end
`ifdef MEM_PREEMPT_EN
    checks++; if (mg_e - e0 !== 2) begin errors++; $display("FAIL pre_grant_edge got %0d exp 2", mg_e - e0); end
    checks++; if ((id_e > md_e) !== 1'b1) begin errors++; $display("FAIL pre_order got if %0d mem %0d exp if later", id_e, md_e); end
`else
    checks++; if ((mg_e > id_e) !== 1'b1) begin errors++; $display("FAIL nopre_order got mem_grant %0d if_done %0d exp mem later", mg_e, id_e); end
    checks++; if (id_e - e0 !== 5) begin errors++; $display("FAIL nopre_if_latency got %0d exp 5", id_e - e0); end
`endif
    checks++; if (nmd !== 1 || nid !== 1) begin errors++; $display("FAIL pre_done_count got mem %0d if %0d exp 1 1", nmd, nid); end
    checks++; if (ifd !== ref_word(32'h3008, 4)) begin errors++; $display("FAIL pre_if_data got %h exp %h", ifd, ref_word(32'h3008, 4)); end
    checks++; if (mrd !== ref_word(32'h30, 1)) begin errors++; $display("FAIL pre_mem_rdata got %h exp %h", mrd, ref_word(32'h30, 1)); end
  endtask

  task automatic test_random();
    int kind, n, lat;
    logic [31:0] a, wd, d;
    logic [1:0]  ln;
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 2));
      a    = 32'h3000 + 32'($urandom_range(0, 31));
      ln   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      n    = len_n(ln);
      case (kind)
        0: begin
          run_if(a, lat, d);
          checks++; if (d !== ref_word(a, 4) || lat !== 5) begin errors++; $display("FAIL rnd_if @%h got %h lat %0d exp %h lat 5", a, d, lat, ref_word(a, 4)); end
        end
        1: begin
          run_mem(1'b1, ln, a, wd, lat, d);
          ref_write(a, wd, n);
          checks++; if (lat !== n) begin errors++; $display("FAIL rnd_wr @%h lat got %0d exp %0d", a, lat, n); end
        end
        default: begin
          run_mem(1'b0, ln, a, 32'h0, lat, d);
          checks++; if (d !== ref_word(a, n) || lat !== n + 1) begin errors++; $display("FAIL rnd_rd @%h got %h lat %0d exp %h lat %0d", a, d, lat, ref_word(a, n), n + 1); end
        end
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00; bus.mem_addr = '0; bus.mem_wdata = '0;
    pl_clr = 1'b1;
    @(posedge clk); #1;
    pl_clr = 1'b0;
    test_reset();
    test_if_fetch();
    test_mem_write();
    test_simultaneous();
    test_flush();
    test_reset_mid_write();
    test_rdy_stall();
    test_wrap();
    test_preempt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
